bcd_updown_counter_n: RTL and testbench

Parametrised multi-digit BCD up/down counter with synchronous load, enable, wrap-or-saturate mode and registered carry/borrow flags. Digits are cascaded internally (ripple enable, single clock), so the block counts 0…(10^DIGITS − 1) in packed BCD. It serves as the general-purpose decimal counter for display, timer and event-tally paths, replacing single-digit counters.

---
 rtl/bcd_pkg.sv | 16 +
 rtl/bcd_digit.sv | 49 ++++
 rtl/bcd_updown_counter_n.sv | 121 ++++++++++++
 tb/tb_bcd_updown_counter_n.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit type, digit limits and a nibble validity check.
package bcd_pkg;

  localparam int unsigned BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  // True when the nibble is a legal decimal digit (0..9).
  function automatic logic is_bcd(input bcd_digit_t nibble);
    return (nibble <= BCD_MAX);
  endfunction

endpackage : bcd_pkg

// File: rtl/bcd_digit.sv
// One BCD digit register with load, increment and decrement.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   inc, dec        - step this digit up / down (inc has priority; top never asserts both)
//   load, load_val  - synchronous load of an already-validated digit
//   digit           - current digit value
//   is9, is0        - combinational decodes of digit
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       dec,
  input  logic       load,
  input  bcd_digit_t load_val,
  output bcd_digit_t digit,
  output logic       is9,
  output logic       is0
);

  bcd_digit_t digit_q;
  bcd_digit_t digit_d;

  // Next digit value: load beats stepping; 9 rolls to 0 and 0 rolls to 9.
  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = load_val;
    end else if (inc) begin
      digit_d = (digit_q == BCD_MAX) ? BCD_MIN : bcd_digit_t'(digit_q + 4'd1);
    end else if (dec) begin
      digit_d = (digit_q == BCD_MIN) ? BCD_MAX : bcd_digit_t'(digit_q - 4'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digit_q <= BCD_MIN;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit = digit_q;
  assign is9   = (digit_q == BCD_MAX);
  assign is0   = (digit_q == BCD_MIN);

endmodule : bcd_digit

// File: rtl/bcd_updown_counter_n.sv
// Multi-digit packed-BCD up/down counter with synchronous load, enable,
// wrap-or-saturate limits and registered carry/borrow/load-error pulses.
// Parameters:
//   DIGITS - number of BCD digits (>= 1)
//   WRAP   - 1: roll over at the limits, 0: saturate
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   en, up, down          - step request (exactly one of up/down with en)
//   load, load_value      - synchronous parallel load (rejected if any nibble > 9)
//   count                 - packed BCD count, digit 0 in [3:0]
//   carry_out, borrow_out - one-cycle pulse on max->0 / 0->max wrap
//   at_max, at_min        - combinational decodes of count
//   load_err              - one-cycle pulse when a load is rejected
module bcd_updown_counter_n
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter bit          WRAP   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  down,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   count,
  output logic                  carry_out,
  output logic                  borrow_out,
  output logic                  at_max,
  output logic                  at_min,
  output logic                  load_err
);

  localparam int unsigned CNT_W = BCD_W * DIGITS;

  logic [DIGITS-1:0] is9;
  logic [DIGITS-1:0] is0;
  logic              all9;
  logic              all0;
  logic              load_ok;
  logic              step_up;
  logic              step_dn;
  logic              move_up;
  logic              move_dn;

  logic carry_q,    carry_d;
  logic borrow_q,   borrow_d;
  logic load_err_q, load_err_d;

  assign all9 = &is9;
  assign all0 = &is0;

  // Load is accepted only if every nibble is a legal digit.
  always_comb begin
    load_ok = 1'b1;
    for (int k = 0; k < int'(DIGITS); k++) begin
      load_ok = load_ok & is_bcd(load_value[BCD_W*k +: BCD_W]);
    end
  end

  // A step needs en and exactly one direction; load pre-empts stepping.
  assign step_up = en & up & ~down & ~load;
  assign step_dn = en & down & ~up & ~load;

  // In saturate mode a step at the limit is suppressed entirely.
  assign move_up = step_up & (WRAP | ~all9);
  assign move_dn = step_dn & (WRAP | ~all0);

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    logic lower9;
    logic lower0;

    // Digit g steps only when every lower digit is at its roll-over value.
    if (g == 0) begin : g_lsd
      assign lower9 = 1'b1;
      assign lower0 = 1'b1;
    end else begin : g_upper
      assign lower9 = &is9[g-1:0];
      assign lower0 = &is0[g-1:0];
    end

    bcd_digit u_digit (
      .clk      (clk),
      .reset    (reset),
      .inc      (move_up & lower9),
      .dec      (move_dn & lower0),
      .load     (load & load_ok),
      .load_val (load_value[BCD_W*g +: BCD_W]),
      .digit    (count[BCD_W*g +: BCD_W]),
      .is9      (is9[g]),
      .is0      (is0[g])
    );
  end

  // Event pulses for the coming edge.
  always_comb begin
    carry_d    = step_up & all9 & WRAP;
    borrow_d   = step_dn & all0 & WRAP;
    load_err_d = load & ~load_ok;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      carry_q    <= 1'b0;
      borrow_q   <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      carry_q    <= carry_d;
      borrow_q   <= borrow_d;
      load_err_q <= load_err_d;
    end
  end

  assign carry_out  = carry_q;
  assign borrow_out = borrow_q;
  assign load_err   = load_err_q;
  assign at_max     = all9;
  assign at_min     = (count == CNT_W'(0));

endmodule : bcd_updown_counter_n

// File: tb/tb_bcd_updown_counter_n.sv
// Directed bench: one wrapping and one saturating 4-digit instance share stimulus.
module tb_bcd_updown_counter_n;

  logic        clk = 1'b0;
  logic        reset, en, up, down, load;
  logic [15:0] load_value;

  logic [15:0] w_count, s_count;
  logic        w_carry, w_borrow, w_max, w_min, w_lerr;
  logic        s_carry, s_borrow, s_max, s_min, s_lerr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bcd_updown_counter_n #(.DIGITS(4), .WRAP(1'b1)) u_wrap (
    .clk(clk), .reset(reset), .en(en), .up(up), .down(down), .load(load),
    .load_value(load_value), .count(w_count), .carry_out(w_carry),
    .borrow_out(w_borrow), .at_max(w_max), .at_min(w_min), .load_err(w_lerr)
  );

  bcd_updown_counter_n #(.DIGITS(4), .WRAP(1'b0)) u_sat (
    .clk(clk), .reset(reset), .en(en), .up(up), .down(down), .load(load),
    .load_value(load_value), .count(s_count), .carry_out(s_carry),
    .borrow_out(s_borrow), .at_max(s_max), .at_min(s_min), .load_err(s_lerr)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs, clock once, sample 1 time unit after the edge.
  task automatic step(input logic r, input logic e, input logic u, input logic d,
                      input logic l, input logic [15:0] lv);
    reset = r; en = e; up = u; down = d; load = l; load_value = lv;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_w(input string tag, input logic [15:0] c, input logic cy,
                       input logic bw, input logic le);
    check({tag, " w.count"},  w_count, c);
    check({tag, " w.carry"},  16'(w_carry), 16'(cy));
    check({tag, " w.borrow"}, 16'(w_borrow), 16'(bw));
    check({tag, " w.lerr"},   16'(w_lerr), 16'(le));
    check({tag, " w.at_max"}, 16'(w_max), 16'(c == 16'h9999));
    check({tag, " w.at_min"}, 16'(w_min), 16'(c == 16'h0000));
  endtask

  task automatic chk_s(input string tag, input logic [15:0] c, input logic cy,
                       input logic bw, input logic le);
    check({tag, " s.count"},  s_count, c);
    check({tag, " s.carry"},  16'(s_carry), 16'(cy));
    check({tag, " s.borrow"}, 16'(s_borrow), 16'(bw));
    check({tag, " s.lerr"},   16'(s_lerr), 16'(le));
    check({tag, " s.at_max"}, 16'(s_max), 16'(c == 16'h9999));
    check({tag, " s.at_min"}, 16'(s_min), 16'(c == 16'h0000));
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; up = 1'b0; down = 1'b0; load = 1'b0; load_value = '0;

    // Reset state
    step(1, 0, 0, 0, 0, 16'h0000);
    chk_w("reset", 16'h0000, 0, 0, 0);
    chk_s("reset", 16'h0000, 0, 0, 0);

    // Multi-digit carry ripple 0199 -> 0200 -> 0201
    step(0, 0, 0, 0, 1, 16'h0199);
    chk_w("ld0199", 16'h0199, 0, 0, 0);
    step(0, 1, 1, 0, 0, 16'h0000);
    chk_w("up0200", 16'h0200, 0, 0, 0);
    step(0, 1, 1, 0, 0, 16'h0000);
    chk_w("up0201", 16'h0201, 0, 0, 0);

    // Borrow ripple 1000 -> 0999
    step(0, 0, 0, 0, 1, 16'h1000);
    step(0, 1, 0, 1, 0, 16'h0000);
    chk_w("dn0999", 16'h0999, 0, 0, 0);
    chk_s("dn0999", 16'h0999, 0, 0, 0);

    // Wrap at max, then wrap back at min
    step(0, 0, 0, 0, 1, 16'h9999);
    chk_w("ld9999", 16'h9999, 0, 0, 0);
    step(0, 1, 1, 0, 0, 16'h0000);
    chk_w("wrap_up", 16'h0000, 1, 0, 0);
    step(0, 1, 0, 1, 0, 16'h0000);
    chk_w("wrap_dn", 16'h9999, 0, 1, 0);
    step(0, 0, 0, 0, 0, 16'h0000);
    chk_w("idle", 16'h9999, 0, 0, 0);

    // Saturate at max for 3 up cycles; wrap instance pulses carry only once
    step(0, 0, 0, 0, 1, 16'h9999);
    step(0, 1, 1, 0, 0, 16'h0000);
    chk_s("sat_up1", 16'h9999, 0, 0, 0);
    chk_w("sat_up1", 16'h0000, 1, 0, 0);
    step(0, 1, 1, 0, 0, 16'h0000);
    chk_s("sat_up2", 16'h9999, 0, 0, 0);
    chk_w("sat_up2", 16'h0001, 0, 0, 0);
    step(0, 1, 1, 0, 0, 16'h0000);
    chk_s("sat_up3", 16'h9999, 0, 0, 0);
    chk_w("sat_up3", 16'h0002, 0, 0, 0);

    // Saturate at min
    step(0, 0, 0, 0, 1, 16'h0000);
    step(0, 1, 0, 1, 0, 16'h0000);
    chk_s("sat_dn", 16'h0000, 0, 0, 0);
    chk_w("sat_dn", 16'h9999, 0, 1, 0);

    // Rejected load holds count and pulses load_err; valid load follows
    step(0, 0, 0, 0, 1, 16'h0042);
    step(0, 0, 0, 0, 1, 16'h12A4);
    chk_w("bad_ld", 16'h0042, 0, 0, 1);
    chk_s("bad_ld", 16'h0042, 0, 0, 1);
    step(0, 0, 0, 0, 1, 16'h1234);
    chk_w("good_ld", 16'h1234, 0, 0, 0);
    step(0, 0, 0, 0, 1, 16'h9000);
    chk_w("ld9000", 16'h9000, 0, 0, 0);

    // Hold cases: up=down=1, then en=0 with up=1
    step(0, 0, 0, 0, 1, 16'h0500);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 1, 1, 0, 16'h0000);
      chk_w("both", 16'h0500, 0, 0, 0);
    end
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 0, 0, 16'h0000);
      chk_w("no_en", 16'h0500, 0, 0, 0);
    end

    // Load beats count
    step(0, 1, 1, 0, 1, 16'h0777);
    chk_w("ld_prio", 16'h0777, 0, 0, 0);
    chk_s("ld_prio", 16'h0777, 0, 0, 0);

    // Reset beats load and up
    step(0, 0, 0, 0, 1, 16'h0005);
    step(0, 1, 1, 0, 0, 16'h0000);
    chk_w("up0006", 16'h0006, 0, 0, 0);
    step(1, 1, 1, 0, 1, 16'h0300);
    chk_w("rst_prio", 16'h0000, 0, 0, 0);
    chk_s("rst_prio", 16'h0000, 0, 0, 0);

    // Reset also clears a pending pulse: wrap then reset in the next cycle
    step(0, 0, 0, 0, 1, 16'h9999);
    step(0, 1, 1, 0, 0, 16'h0000);
    chk_w("pre_rst", 16'h0000, 1, 0, 0);
    step(1, 1, 1, 0, 0, 16'h0000);
    chk_w("rst_clr", 16'h0000, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_bcd_updown_counter_n
